// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state type and default settings for the clock divider controller
package clk_div_pkg;

    localparam int DIV_W              = 8;
    localparam int DEF_DIV            = 2;
    localparam int DEF_MIN_DIV        = 1;
    localparam int DEF_SETTLE_PERIODS = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BND = 2'd1,
        SETTLE   = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/clk_div_phase.sv
// rtl/clk_div_phase.sv - output-period phase counter with last-cycle boundary flag
module clk_div_phase
    import clk_div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] divider,
    output logic [WIDTH-1:0] phase,
    output logic             boundary
);

    logic [WIDTH-1:0] last_phase;

    // Divide values 0 and 1 both give a one-cycle period.
    always_comb begin
        last_phase = '0;
        if (divider > WIDTH'(1)) begin
            last_phase = divider - WIDTH'(1);
        end
    end

    assign boundary = (phase == last_phase);

    // Wrap on >= so a stray phase beyond the period still recovers within one cycle.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (phase >= last_phase) begin
            phase <= '0;
        end else begin
            phase <= phase + WIDTH'(1);
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - divider reconfiguration controller: accepts a new divide value and applies it at a period boundary
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int WIDTH          = DIV_W,
    parameter int DEFAULT_DIV    = DEF_DIV,
    parameter int MIN_DIV        = DEF_MIN_DIV,
    parameter int SETTLE_PERIODS = DEF_SETTLE_PERIODS
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_divider,
    output logic             req_ready,
    input  logic             abort,
    output logic [WIDTH-1:0] divider,
    output logic             boundary,
    output logic             busy,
    output logic             done,
    output logic             clamped
);

    localparam logic [WIDTH-1:0] DEFAULT_W = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_W     = WIDTH'(MIN_DIV);
    localparam logic [WIDTH-1:0] SETTLE_W  = WIDTH'(SETTLE_PERIODS);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] divider_q, divider_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] settle_q, settle_d;
    logic             clamped_q, clamped_d;
    logic [WIDTH-1:0] req_clamped;
    logic             req_low;
    logic [WIDTH-1:0] phase_unused;

    clk_div_phase #(
        .WIDTH(WIDTH)
    ) u_phase (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .divider (divider_q),
        .phase   (phase_unused),
        .boundary(boundary)
    );

    assign req_low     = (req_divider < MIN_W);
    assign req_clamped = req_low ? MIN_W : req_divider;

    assign divider   = divider_q;
    assign clamped   = clamped_q;
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q == WAIT_BND) || (state_q == SETTLE);
    assign done      = (state_q == DONE);

    always_comb begin
        state_d   = state_q;
        divider_d = divider_q;
        pending_d = pending_q;
        settle_d  = settle_q;
        clamped_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    pending_d = req_clamped;
                    clamped_d = req_low;
                    state_d   = (req_clamped == divider_q) ? DONE : WAIT_BND;
                end
            end
            WAIT_BND: begin
                // Abort beats a coincident boundary: nothing is applied.
                if (abort) begin
                    state_d = IDLE;
                end else if (boundary) begin
                    divider_d = pending_q;
                    settle_d  = SETTLE_W;
                    state_d   = (SETTLE_PERIODS == 0) ? DONE : SETTLE;
                end
            end
            SETTLE: begin
                if (boundary) begin
                    settle_d = settle_q - WIDTH'(1);
                    if (settle_q <= WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            divider_q <= DEFAULT_W;
            pending_q <= '0;
            settle_q  <= '0;
            clamped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            divider_q <= divider_d;
            pending_q <= pending_d;
            settle_q  <= settle_d;
            clamped_q <= clamped_d;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - directed self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [7:0] req_divider;
    logic       req_ready;
    logic       abort;
    logic [7:0] divider;
    logic       boundary;
    logic       busy;
    logic       done;
    logic       clamped;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    clk_div_ctrl #(
        .WIDTH         (8),
        .DEFAULT_DIV   (2),
        .MIN_DIV       (1),
        .SETTLE_PERIODS(2)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_divider(req_divider),
        .req_ready  (req_ready),
        .abort      (abort),
        .divider    (divider),
        .boundary   (boundary),
        .busy       (busy),
        .done       (done),
        .clamped    (clamped)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic wait_boundary();
        int k = 0;
        while (!boundary && k < 20) begin
            step();
            k++;
        end
        check("wait_boundary", 32'(boundary), 1);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 100) begin
            step();
            k++;
        end
        check(tag, 32'(done), 1);
    endtask

    task automatic wait_divider(input string tag, input logic [7:0] want);
        int k = 0;
        while (divider !== want && k < 20) begin
            step();
            k++;
        end
        check(tag, 32'(divider), 32'(want));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int changes;
        int dones;
        int bad;
        bit saw_done;
        logic [7:0] prev;

        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_divider = 8'd0;
        abort       = 1'b0;
        step();
        step();

        check("rst_div", 32'(divider), 2);
        check("rst_ready", 32'(req_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_clamped", 32'(clamped), 0);
        check("rst_bnd", 32'(boundary), 0);

        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rst_bnd_seq", 32'(boundary), (i % 2 == 1) ? 1 : 0);
            step();
        end

        // 2 -> 6, accepted in the phase-0 cycle
        wait_boundary();
        step();
        req_valid   = 1'b1;
        req_divider = 8'd6;
        check("c6_acc_ready", 32'(req_ready), 1);
        step();
        req_valid = 1'b0;
        check("c6_wb_busy", 32'(busy), 1);
        check("c6_wb_div", 32'(divider), 2);
        check("c6_wb_bnd", 32'(boundary), 1);
        check("c6_wb_ready", 32'(req_ready), 0);
        step();
        check("c6_apply_div", 32'(divider), 6);
        for (int t = 0; t < 13; t++) begin
            check("c6_bnd", 32'(boundary), (t % 6 == 5) ? 1 : 0);
            check("c6_done", 32'(done), (t == 12) ? 1 : 0);
            check("c6_busy", 32'(busy), (t < 12) ? 1 : 0);
            step();
        end
        check("c6_ready_after", 32'(req_ready), 1);
        check("c6_div_after", 32'(divider), 6);

        // same value: straight to done
        req_valid   = 1'b1;
        req_divider = 8'd6;
        step();
        req_valid = 1'b0;
        check("eq_done", 32'(done), 1);
        check("eq_busy", 32'(busy), 0);
        check("eq_div", 32'(divider), 6);
        check("eq_clamped", 32'(clamped), 0);
        step();
        check("eq_ready", 32'(req_ready), 1);
        check("eq_done_clear", 32'(done), 0);

        // request 0 clamps to 1
        req_valid   = 1'b1;
        req_divider = 8'd0;
        step();
        req_valid = 1'b0;
        check("cl_clamped", 32'(clamped), 1);
        check("cl_busy", 32'(busy), 1);
        check("cl_ready", 32'(req_ready), 0);
        step();
        check("cl_clamped_pulse", 32'(clamped), 0);
        wait_divider("cl_div", 8'd1);
        for (int t = 0; t < 4; t++) begin
            check("cl_bnd", 32'(boundary), 1);
            check("cl_done", 32'(done), (t == 2) ? 1 : 0);
            step();
        end

        // go to 8 for the abort cases
        req_valid   = 1'b1;
        req_divider = 8'd8;
        step();
        req_valid = 1'b0;
        wait_done("to8_done");
        step();
        check("to8_div", 32'(divider), 8);

        // abort two cycles after accept
        wait_boundary();
        step();
        req_valid   = 1'b1;
        req_divider = 8'd3;
        step();
        req_valid = 1'b0;
        step();
        check("ab_busy", 32'(busy), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("ab_div", 32'(divider), 8);
        check("ab_busy_drop", 32'(busy), 0);
        check("ab_ready", 32'(req_ready), 1);
        check("ab_done", 32'(done), 0);
        for (int t = 0; t < 10; t++) begin
            check("ab_hold_div", 32'(divider), 8);
            check("ab_hold_done", 32'(done), 0);
            step();
        end

        // abort coincident with the boundary
        wait_boundary();
        step();
        req_valid   = 1'b1;
        req_divider = 8'd3;
        step();
        req_valid = 1'b0;
        repeat (6) step();
        check("abb_bnd", 32'(boundary), 1);
        check("abb_busy", 32'(busy), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abb_div", 32'(divider), 8);
        check("abb_ready", 32'(req_ready), 1);
        check("abb_busy_drop", 32'(busy), 0);
        for (int t = 0; t < 10; t++) begin
            check("abb_hold_div", 32'(divider), 8);
            check("abb_hold_done", 32'(done), 0);
            step();
        end

        // req_valid held through busy with a second value
        req_valid   = 1'b1;
        req_divider = 8'd5;
        check("hv_ready", 32'(req_ready), 1);
        step();
        req_divider = 8'd4;
        changes  = 0;
        dones    = 0;
        bad      = 0;
        saw_done = 1'b0;
        prev     = 8'd8;
        for (int k = 0; k < 80 && dones < 2; k++) begin
            if (divider !== prev) begin
                changes++;
                check((changes == 1) ? "hv_first_div" : "hv_second_div", 32'(divider),
                      (changes == 1) ? 5 : 4);
                prev = divider;
            end
            if (busy && req_ready) bad++;
            if (saw_done) begin
                check("hv_ready_after_done", 32'(req_ready), 1);
                saw_done = 1'b0;
            end
            if (done) begin
                dones++;
                saw_done = 1'b1;
                if (dones == 2) req_valid = 1'b0;
            end
            step();
        end
        check("hv_changes", changes, 2);
        check("hv_dones", dones, 2);
        check("hv_ready_busy_overlap", bad, 0);
        check("hv_final_div", 32'(divider), 4);
        check("hv_final_ready", 32'(req_ready), 1);

        // asynchronous reset in the middle of settling
        req_valid   = 1'b1;
        req_divider = 8'd7;
        step();
        req_valid = 1'b0;
        wait_divider("ms_div", 8'd7);
        step();
        check("ms_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("ms_rst_div", 32'(divider), 2);
        check("ms_rst_ready", 32'(req_ready), 1);
        check("ms_rst_busy", 32'(busy), 0);
        check("ms_rst_done", 32'(done), 0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check("ms_post_div", 32'(divider), 2);
        check("ms_post_ready", 32'(req_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Reconfiguration controller for the 8-bit programmable clock divider.
- Owns the `divider` control word and accepts new divide values from a host over a valid/ready handshake.
- Applies each change only at an output-period boundary, then waits a programmable number of new periods before reporting completion.
- Sits between the configuration/host logic and the divider instance; the host never drives the divider directly.

Parameters:
- WIDTH, 8: width of the divider word and of the phase counter.
- DEFAULT_DIV, 2: divider value loaded at reset.
- MIN_DIV, 1: smallest legal divider; smaller requests are clamped up to it.
- SETTLE_PERIODS, 2: number of complete new-divider periods to wait after apply before done; 0 is legal.

Ports:
- clk_in, input, 1: single system clock; also the divider's input clock.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- req_valid, input, 1: host request strobe.
- req_divider, input, WIDTH: requested divide value.
- req_ready, output, 1: controller can accept a request.
- abort, input, 1: cancels a pending, not-yet-applied change.
- divider, output, WIDTH: control word to the divider; registered.
- boundary, output, 1: one-cycle pulse on the last clk_in cycle of each output period.
- busy, output, 1: high from accept until done.
- done, output, 1: one-cycle completion pulse.
- clamped, output, 1: one-cycle pulse when the accepted request was raised to MIN_DIV.

Behaviour:
- Reset (asynchronous, rst_n=0). All of the following take effect immediately:
  - divider=DEFAULT_DIV, phase=0, state=IDLE.
  - req_ready=1; busy, done, clamped, boundary all 0; pending=0; settle_cnt=0.
  - Reset mid-operation discards any pending request and restores DEFAULT_DIV.
- Period model:
  - P = 1 if divider<=1, else P = divider (clk_in cycles).
  - phase counts 0..P-1 and wraps to 0.
  - boundary = (phase==P-1), combinational from registered phase; constantly 1 when P=1.
- States: IDLE, WAIT_BND, SETTLE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: pending = max(req_divider, MIN_DIV).
  - clamped pulses in the cycle after accept if clamping occurred.
  - busy=1 from the next cycle.
  - If pending==divider, go to DONE (no apply, no settle). Otherwise go to WAIT_BND.
- WAIT_BND:
  - req_ready=0.
  - If abort=1: go to IDLE next cycle; divider unchanged; no done pulse; busy drops.
  - Else, on a cycle with boundary=1: at the next edge divider<=pending and phase<=0, settle_cnt<=SETTLE_PERIODS. Go to DONE if SETTLE_PERIODS==0, else to SETTLE.
  - Abort and boundary in the same cycle: abort wins and nothing is applied.
- SETTLE:
  - abort is ignored.
  - On each boundary, settle_cnt decrements. On the boundary where settle_cnt==1, go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0 in that cycle; go to IDLE.
  - req_ready returns to 1 in the following cycle.
- Requests while req_ready=0 are not accepted; the host holds req_valid.
- Latency:
  - Accept to apply ≤ P_old cycles after entering WAIT_BND.
  - Apply to done = SETTLE_PERIODS*P_new + 1 cycles.
- The divider output changes only at a phase wrap, never mid-period.
- Arithmetic is unsigned WIDTH-bit; the phase counter cannot overflow because P ≤ 2^WIDTH-1.
- divider=0 is never produced once MIN_DIV ≥ 1.

Decomposition:
- Package clk_div_pkg holds:
  - the state enum (IDLE, WAIT_BND, SETTLE, DONE);
  - DIV_W=8;
  - default values for DEFAULT_DIV, MIN_DIV and SETTLE_PERIODS.
- One sub-module, clk_div_phase: a phase counter taking divider and producing phase and boundary, with reset to 0. The FSM, pending register, settle counter and handshake stay in clk_div_ctrl.

Test Plan:
- Reset with DEFAULT_DIV=2 → divider=2, req_ready=1, busy=0; boundary pulses every 2nd cycle; asserting rst_n=0 mid-SETTLE immediately restores divider=2 and state IDLE.
- Change 2→6 with SETTLE_PERIODS=2:
  - accept when phase=0;
  - divider becomes 6 two cycles later, at the wrap;
  - boundary then pulses every 6 cycles;
  - done pulses 13 cycles after apply;
  - req_ready=1 one cycle later.
- Request 0 with MIN_DIV=1 → clamped pulse; divider applied = 1; boundary continuously high; done after SETTLE_PERIODS*1+1 cycles.
- Request equal to current divider (6→6) → no divider change, no WAIT_BND; done one cycle after accept.
- Abort in WAIT_BND (divider=8, request 3, abort asserted 2 cycles after accept):
  - divider stays 8, no done, busy=0, req_ready=1.
  - Repeat with abort coincident with boundary → divider still 8.
- req_valid held high during busy with a second value 4 → not accepted until the cycle after done; then processed normally, with a single apply per request.
